// File: rtl/fechadura_sequencial_if.sv
// Handshake bundle between the code-lock controller and its surroundings:
// user strobe, comparator result, expected key digit and status outputs.
interface fechadura_sequencial_if #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned IdxW = $clog2(N_DIGITS);
  localparam int unsigned FcW  = $clog2(MAX_FAILS + 1);

  logic            strobe;
  logic            eq;
  logic [1:0]      key_digit;
  logic [IdxW-1:0] digit_idx;
  logic            unlocked;
  logic            locked_out;
  logic            fail;
  logic [FcW-1:0]  fail_count;

  // User side: provides the strobe and the comparator result.
  modport master (
    output strobe,
    output eq,
    input  key_digit,
    input  digit_idx,
    input  unlocked,
    input  locked_out,
    input  fail,
    input  fail_count
  );

  // Lock controller side.
  modport slave (
    input  strobe,
    input  eq,
    output key_digit,
    output digit_idx,
    output unlocked,
    output locked_out,
    output fail,
    output fail_count
  );
endinterface

// File: rtl/fechadura_sequencial.sv
// Sequential code-lock controller. Presents the expected key digit to an
// external equality comparator, accumulates mismatches over a full entry,
// then opens for OPEN_CYCLES or counts failures up to a lockout period.
module fechadura_sequencial #(
  parameter int unsigned           N_DIGITS       = 4,
  parameter logic [2*N_DIGITS-1:0] KEY            = 8'b00_11_01_10,
  parameter int unsigned           MAX_FAILS      = 3,
  parameter int unsigned           OPEN_CYCLES    = 500,
  parameter int unsigned           LOCKOUT_CYCLES = 1000
) (
  input logic                     clk,
  input logic                     rst,
  fechadura_sequencial_if.slave   bus
);

  localparam int unsigned IdxW   = $clog2(N_DIGITS);
  localparam int unsigned FcW    = $clog2(MAX_FAILS + 1);
  localparam int unsigned MaxCyc = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [IdxW-1:0]   LastIdx     = IdxW'(N_DIGITS - 1);
  localparam logic [FcW-1:0]    FcLast      = FcW'(MAX_FAILS - 1);
  localparam logic [FcW-1:0]    FcMax       = FcW'(MAX_FAILS);
  localparam logic [TimerW-1:0] OpenLoad    = TimerW'(OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] LockoutLoad = TimerW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {StEnter, StOpen, StLockout} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   digit_idx_q;
  logic              err_q;
  logic [FcW-1:0]    fail_count_q;
  logic [TimerW-1:0] timer_q;
  logic              unlocked_q;
  logic              locked_out_q;
  logic              fail_q;

  // Controller FSM with registered status outputs; timer shared by OPEN and LOCKOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StEnter;
      digit_idx_q  <= '0;
      err_q        <= 1'b0;
      fail_count_q <= '0;
      timer_q      <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      unique case (state_q)
        StEnter: begin
          if (bus.strobe) begin
            if (digit_idx_q != LastIdx) begin
              // Mismatches are only remembered, never reported before the last digit.
              err_q       <= err_q | ~bus.eq;
              digit_idx_q <= digit_idx_q + 1'b1;
            end else begin
              digit_idx_q <= '0;
              err_q       <= 1'b0;
              if (!err_q && bus.eq) begin
                state_q      <= StOpen;
                timer_q      <= OpenLoad;
                fail_count_q <= '0;
                unlocked_q   <= 1'b1;
              end else begin
                fail_q <= 1'b1;
                if (fail_count_q == FcLast) begin
                  state_q      <= StLockout;
                  timer_q      <= LockoutLoad;
                  fail_count_q <= FcMax;
                  locked_out_q <= 1'b1;
                end else begin
                  fail_count_q <= fail_count_q + 1'b1;
                end
              end
            end
          end
        end
        StOpen: begin
          if (timer_q == '0) begin
            state_q    <= StEnter;
            unlocked_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StLockout: begin
          if (timer_q == '0) begin
            state_q      <= StEnter;
            fail_count_q <= '0;
            locked_out_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= StEnter;
      endcase
    end
  end

  // Expected digit follows the registered position; feeds comparator operand B.
  always_comb begin
    bus.key_digit = KEY[2*digit_idx_q +: 2];
  end

  // Status outputs straight from registers.
  always_comb begin
    bus.digit_idx  = digit_idx_q;
    bus.unlocked   = unlocked_q;
    bus.locked_out = locked_out_q;
    bus.fail       = fail_q;
    bus.fail_count = fail_count_q;
  end

endmodule
